// File: rtl/seq_restoring_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_restoring_divider                                      |
// | Description : Unsigned radix-2 restoring divider, one quotient bit per   |
// |               clock. Optional macro DIV_ZERO_CHECK_EN short-circuits a   |
// |               zero divisor straight to DONE and raises div_zero.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int                C_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic               w_accept;
    logic               w_zero_skip;
    logic               w_last;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_dvd_next;

`ifdef DIV_ZERO_CHECK_EN
    logic               r_div_zero;
    assign w_zero_skip = (divisor == '0);
    assign div_zero    = r_div_zero;
`else
    assign w_zero_skip = 1'b0;
    assign div_zero    = 1'b0;
`endif

    assign w_accept = start && (r_state != S_BUSY);
    assign w_last   = (r_cnt == C_LAST);

    // The partial remainder is always below the divisor, so the low WIDTH
    // bits of the difference are exact whenever the trial subtract succeeds.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_diff     = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero_skip ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_next = w_zero_skip ? S_DONE : S_BUSY;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_dvs       <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
            r_div_zero  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_dvs <= divisor;
            r_dvd <= dividend;
            r_rem <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (w_zero_skip) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
                r_div_zero  <= 1'b1;
            end
`endif
        end else if (r_state == S_BUSY) begin
            r_rem <= w_rem_next;
            r_dvd <= w_dvd_next;
            if (w_last) begin
                r_cnt       <= '0;
                r_quotient  <= w_dvd_next;
                r_remainder <= w_rem_next;
`ifdef DIV_ZERO_CHECK_EN
                r_div_zero  <= 1'b0;
`endif
            end else begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state == S_BUSY);
    assign done      = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// Testbench for seq_restoring_divider (WIDTH=8): directed vectors, expected
// results queued at issue time and checked by an independent done monitor.
module tb_seq_restoring_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int q;
        int r;
        int dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

`ifdef DIV_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the following negedge (cycle after the accepting edge).
    task automatic issue(input int a, input int b, input int q, input int r);
        exp_t e;
        bit   skip;
        skip  = ZCHK && (b == 0);
        e.due = cyc + 1 + (skip ? 0 : WIDTH);
        e.q   = q;
        e.r   = r;
        e.dz  = skip ? 1 : 0;
        sb.push_back(e);
        start    = 1'b1;
        dividend = a[WIDTH-1:0];
        divisor  = b[WIDTH-1:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("quotient", int'(quotient), e.q);
                chk("remainder", int'(remainder), e.r);
                chk("div_zero", int'(div_zero), e.dz);
                chk("busy_in_done", int'(busy), 0);
            end
        end
    end

    initial begin
        int vec [4][4] = '{'{0, 5, 0, 0}, '{255, 255, 1, 0}, '{254, 16, 15, 14}, '{7, 8, 0, 7}};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_div_zero", int'(div_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100/7 with busy window
        issue(100, 7, 14, 2);
        for (int i = 0; i < WIDTH; i++) begin
            chk("busy_window", int'(busy), 1);
            @(negedge clk);
        end
        chk("done_pulse", int'(done), 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("hold_q_100_7", int'(quotient), 14);

        // 255/1 then 5/9, results held
        issue(255, 1, 255, 0);
        wait_done("d255");
        @(negedge clk);
        chk("hold_q_255", int'(quotient), 255);
        chk("hold_r_255", int'(remainder), 0);
        issue(5, 9, 0, 5);
        wait_done("d5");
        repeat (3) @(negedge clk);
        chk("hold_q_5_9", int'(quotient), 0);
        chk("hold_r_5_9", int'(remainder), 5);

        // zero divisor
        issue(200, 0, 255, 200);
        wait_done("dz");
        @(negedge clk);

        // start while busy is ignored
        issue(100, 7, 14, 2);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign");
        @(negedge clk);

        // back-to-back start in the done cycle
        issue(100, 7, 14, 2);
        wait_done("b2b_a");
        issue(9, 3, 3, 0);
        chk("b2b_busy", int'(busy), 1);
        wait_done("b2b_b");
        @(negedge clk);

        // reset mid-operation
        issue(100, 7, 14, 2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_div_zero", int'(div_zero), 0);
        rst_n = 1'b1;
        issue(50, 6, 8, 2);
        wait_done("post_rst");
        @(negedge clk);

        foreach (vec[i]) begin
            issue(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
            wait_done("vec");
            @(negedge clk);
        end

        repeat (12) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL provide port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL provide port start, input, 1 bit, a request to begin a division.
REQ-005 The block SHALL provide port dividend, input, WIDTH bits, the unsigned dividend, sampled on the accepting edge.
REQ-006 The block SHALL provide port divisor, input, WIDTH bits, the unsigned divisor, sampled on the accepting edge.
REQ-007 The block SHALL provide port busy, output, 1 bit, high while an iteration is in progress.
REQ-008 The block SHALL provide port done, output, 1 bit, a one-cycle pulse marking the result as valid.
REQ-009 The block SHALL provide port quotient, output, WIDTH bits, the result quotient.
REQ-010 The block SHALL provide port remainder, output, WIDTH bits, the result remainder.
REQ-011 The block SHALL provide port div_zero, output, 1 bit, the divide-by-zero flag for the last result.

Function
REQ-012 The block SHALL implement a restoring divider with states IDLE, BUSY and DONE.
REQ-013 start SHALL be accepted on an edge where busy=0, in either IDLE or DONE.
  - The accepting edge SHALL latch both operands.
  - The block SHALL enter BUSY, or DONE in the zero-divisor case of REQ-024.
REQ-014 In BUSY, each cycle SHALL perform one step:
  - shift the (WIDTH+1)-bit partial remainder left, bringing in the next dividend MSB;
  - trial-subtract the divisor;
  - keep the difference and set the quotient bit to 1 if it is non-negative;
  - otherwise restore the partial remainder and set the quotient bit to 0.
REQ-015 The block SHALL use an iteration counter of $clog2(WIDTH)+1 bits that leaves BUSY after exactly WIDTH steps.
REQ-016 Timing for a start accepted at edge T SHALL be:
  - busy=1 from T+1 through T+WIDTH;
  - done=1 at T+WIDTH+1 for exactly one cycle;
  - busy=0 during the DONE cycle.
REQ-017 quotient, remainder and div_zero SHALL update only in the DONE cycle and SHALL hold until the next DONE cycle or reset.
REQ-018 quotient and remainder SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every non-zero divisor.
REQ-019 start asserted while busy=1 SHALL be ignored, with no effect on the operands, counter or result.
REQ-020 A start in the DONE cycle SHALL begin a new division back-to-back, with busy=1 on the next cycle.
REQ-021 After DONE with no new start, the block SHALL return to IDLE.

Reset
REQ-022 While rst_n=0 at a rising edge, the block SHALL:
  - force busy=0, done=0, quotient=0, remainder=0 and div_zero=0;
  - force the state to IDLE and the counter to 0.
REQ-023 A reset asserted mid-operation SHALL abort the division with no done pulse, and the block SHALL accept start on the first edge with rst_n=1.

Configuration
REQ-024 With macro DIV_ZERO_CHECK_EN defined, a start with divisor=0 SHALL skip BUSY and give, in the DONE cycle at T+1:
  - done=1 and div_zero=1;
  - quotient all ones;
  - remainder=dividend.
REQ-025 With DIV_ZERO_CHECK_EN undefined, divisor=0 SHALL run the full WIDTH steps and give quotient all ones and remainder=dividend at T+WIDTH+1, with div_zero tied to 0.

Verification (WIDTH=8)
REQ-026 Start at T with 100/7 -> busy for T+1..T+8; at T+9 done=1, quotient=14, remainder=2.
REQ-027 Run 255/1 and then 5/9 -> quotient=255, remainder=0; then quotient=0, remainder=5; results held after done falls.
REQ-028 Start with 200/0 -> with DIV_ZERO_CHECK_EN: done at T+1, quotient=255, remainder=200, div_zero=1; without it: done at T+9, quotient=255, remainder=200, div_zero=0.
REQ-029 Start 100/7, pulse start with 9/3 at T+4 -> ignored; T+9 gives quotient=14, remainder=2.
REQ-030 Start 100/7, then start 9/3 in the done cycle T+9 -> busy from T+10; T+18 gives quotient=3, remainder=0.
REQ-031 Start 100/7, rst_n=0 at T+5 -> all outputs 0 at T+6 and no done pulse; a start after rst_n=1 completes normally.
